// File: rtl/ddr2pbuf_stream.sv
// DDR read-stream to PE parameter-buffer loader: UNIT_N-lane scatter from a programmable
// base address, with ready/valid backpressure toward DDR, pbuf write stall and abort.
//
// state | meaning
// IDLE  | waiting for start; done high
// RUN   | accepting DDR beats into the output stage
// DRAIN | last beat accepted; waiting for its write to retire
module ddr2pbuf_stream #(
    parameter int BATCH     = 4,
    parameter int DATA_W    = 8,
    parameter int DDR_W     = BATCH * DATA_W,
    parameter int BUF_DEPTH = 256,
    parameter int ADDR_W    = $clog2(BUF_DEPTH),
    parameter int PE_NUM    = 32,
    parameter int UNIT_N    = 4,
    parameter int PIX_W     = 4,
    parameter int CH_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    output logic                    done,
    input  logic                    conf_mode,
    input  logic [15:0]             conf_trans_num,
    input  logic [CH_W-1:0]         conf_ch_num,
    input  logic [PIX_W-1:0]        conf_pix_num,
    input  logic                    conf_depool,
    input  logic [ADDR_W-1:0]       conf_base_addr,
    input  logic [PE_NUM-1:0]       conf_mask,
    input  logic [DDR_W-1:0]        ddr1_data,
    input  logic                    ddr1_valid,
    output logic                    ddr1_ready,
    input  logic [DDR_W-1:0]        ddr2_data,
    input  logic                    ddr2_valid,
    output logic                    ddr2_ready,
    input  logic                    pbuf_stall,
    output logic [UNIT_N*DDR_W-1:0] pbuf_wr_data,
    output logic [ADDR_W-1:0]       pbuf_wr_addr,
    output logic [PE_NUM-1:0]       pbuf_wr_en,
    output logic [15:0]             beat_cnt
);

    localparam int LANE_W = $clog2(UNIT_N);
    localparam int OUT_W  = UNIT_N * DDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              mode_q;
    logic [15:0]       trans_q;
    logic [CH_W-1:0]   ch_num_q;
    logic [PIX_W-1:0]  pix_num_q;
    logic              depool_q;
    logic [ADDR_W-1:0] base_q;
    logic [PE_NUM-1:0] mask_q;

    logic [CH_W-1:0]   ch;
    logic [PIX_W-1:0]  pix;
    logic [PIX_W:0]    pix_step;
    logic [PIX_W:0]    pix_adv;

    logic              out_vld;
    logic              can_acc;
    logic              joint_ok;
    logic              acc;
    logic              retire;
    logic              last;
    logic              start_ok;

    logic [DDR_W-1:0]  beat;
    logic [OUT_W-1:0]  wr_data_nxt;
    logic [PE_NUM-1:0] wr_en_nxt;
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic [ADDR_W-1:0] upd_off;
    logic [31:0]       lane_sel;

    assign start_ok = (state == S_IDLE) && start && !abort;
    assign can_acc  = (state == S_RUN) && (!out_vld || !pbuf_stall);
    assign joint_ok = can_acc && ddr1_valid && ddr2_valid;
    assign ddr1_ready = mode_q ? joint_ok : 1'b0;
    assign ddr2_ready = mode_q ? joint_ok : can_acc;
    assign acc      = ddr2_valid && ddr2_ready;
    assign retire   = out_vld && !pbuf_stall;
    assign done     = (state == S_IDLE);

    assign pix_step = depool_q ? (PIX_W+1)'(UNIT_N) : (PIX_W+1)'(1);
    assign pix_adv  = {1'b0, pix} + pix_step;
    assign last     = mode_q ? ((ch == ch_num_q) && (pix_adv > {1'b0, pix_num_q}))
                             : (beat_cnt == trans_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (acc && last) state_nxt = S_DRAIN;
            S_DRAIN: if (!out_vld || !pbuf_stall) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    // Update-mode address: channel in the high bits, pixel group in the low bits.
    always_comb begin
        upd_off  = (ADDR_W'(ch) << (PIX_W - LANE_W)) | ADDR_W'(pix >> LANE_W);
        lane_sel = 32'(pix) % 32'(UNIT_N);

        beat = mode_q ? ddr1_data : ddr2_data;
        if (mode_q && depool_q) begin
            for (int i = 0; i < BATCH; i++) begin
                beat[i*DATA_W +: DATA_W] = (ddr2_data[i*DATA_W +: DATA_W] != '0)
                                         ? ddr1_data[i*DATA_W +: DATA_W] : '0;
            end
        end

        wr_data_nxt = '0;
        for (int l = 0; l < UNIT_N; l++) begin
            wr_data_nxt[l*DDR_W +: DDR_W] = beat;
        end

        wr_en_nxt = mask_q;
        if (mode_q && !depool_q) begin
            for (int p = 0; p < PE_NUM; p++) begin
                if (32'(p % UNIT_N) != lane_sel) wr_en_nxt[p] = 1'b0;
            end
        end

        wr_addr_nxt = mode_q ? (base_q + upd_off) : (base_q + beat_cnt[ADDR_W-1:0]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q    <= 1'b0;
            trans_q   <= '0;
            ch_num_q  <= '0;
            pix_num_q <= '0;
            depool_q  <= 1'b0;
            base_q    <= '0;
            mask_q    <= '0;
        end else if (start_ok) begin
            mode_q    <= conf_mode;
            trans_q   <= conf_trans_num;
            ch_num_q  <= conf_ch_num;
            pix_num_q <= conf_pix_num;
            depool_q  <= conf_depool;
            base_q    <= conf_base_addr;
            mask_q    <= conf_mask;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch       <= '0;
            pix      <= '0;
            beat_cnt <= '0;
        end else if (start_ok) begin
            ch       <= '0;
            pix      <= '0;
            beat_cnt <= '0;
        end else if (acc && !abort) begin
            if (beat_cnt != 16'hFFFF) beat_cnt <= beat_cnt + 16'd1;
            if (ch == ch_num_q) begin
                ch  <= '0;
                pix <= pix_adv[PIX_W-1:0];
            end else begin
                ch  <= ch + CH_W'(1);
            end
        end
    end

    // Single output register stage; an accept always coincides with retirement of any held write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld      <= 1'b0;
            pbuf_wr_en   <= '0;
            pbuf_wr_addr <= '0;
            pbuf_wr_data <= '0;
        end else if (abort) begin
            out_vld      <= 1'b0;
            pbuf_wr_en   <= '0;
        end else if (acc) begin
            out_vld      <= 1'b1;
            pbuf_wr_en   <= wr_en_nxt;
            pbuf_wr_addr <= wr_addr_nxt;
            pbuf_wr_data <= wr_data_nxt;
        end else if (retire) begin
            out_vld      <= 1'b0;
            pbuf_wr_en   <= '0;
        end
    end

endmodule

// File: tb/tb_ddr2pbuf_stream.sv
// Randomized bench for ddr2pbuf_stream: accepted beats are mapped to expected pbuf writes
// by an arithmetic model of the scatter rules and compared against the retired writes.
module tb_ddr2pbuf_stream;

    localparam int BATCH = 4, DATA_W = 8, DDR_W = 32, BUF_DEPTH = 256, ADDR_W = 8;
    localparam int PE_NUM = 32, UNIT_N = 4, PIX_W = 4, CH_W = 4, LANE_W = 2;
    localparam int OUT_W = UNIT_N * DDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0, abort = 1'b0, done;
    logic              conf_mode = 1'b0, conf_depool = 1'b0;
    logic [15:0]       conf_trans_num = '0;
    logic [CH_W-1:0]   conf_ch_num = '0;
    logic [PIX_W-1:0]  conf_pix_num = '0;
    logic [ADDR_W-1:0] conf_base_addr = '0;
    logic [PE_NUM-1:0] conf_mask = '0;
    logic [DDR_W-1:0]  ddr1_data = '0, ddr2_data = '0;
    logic              ddr1_valid = 1'b0, ddr2_valid = 1'b0, ddr1_ready, ddr2_ready;
    logic              pbuf_stall = 1'b0;
    logic [OUT_W-1:0]  pbuf_wr_data;
    logic [ADDR_W-1:0] pbuf_wr_addr;
    logic [PE_NUM-1:0] pbuf_wr_en;
    logic [15:0]       beat_cnt;

    always #5 clk = ~clk;

    ddr2pbuf_stream #(
        .BATCH(BATCH), .DATA_W(DATA_W), .DDR_W(DDR_W), .BUF_DEPTH(BUF_DEPTH), .ADDR_W(ADDR_W),
        .PE_NUM(PE_NUM), .UNIT_N(UNIT_N), .PIX_W(PIX_W), .CH_W(CH_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .done(done),
        .conf_mode(conf_mode), .conf_trans_num(conf_trans_num), .conf_ch_num(conf_ch_num),
        .conf_pix_num(conf_pix_num), .conf_depool(conf_depool), .conf_base_addr(conf_base_addr),
        .conf_mask(conf_mask),
        .ddr1_data(ddr1_data), .ddr1_valid(ddr1_valid), .ddr1_ready(ddr1_ready),
        .ddr2_data(ddr2_data), .ddr2_valid(ddr2_valid), .ddr2_ready(ddr2_ready),
        .pbuf_stall(pbuf_stall), .pbuf_wr_data(pbuf_wr_data), .pbuf_wr_addr(pbuf_wr_addr),
        .pbuf_wr_en(pbuf_wr_en), .beat_cnt(beat_cnt)
    );

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] got_addr[$];
    logic [PE_NUM-1:0] got_en[$];
    logic [OUT_W-1:0]  got_data[$];
    int                got_cyc[$];
    logic [DDR_W-1:0]  acc1[$], acc2[$];
    int                acc_cyc[$];
    int                done_cyc, viol_hold, viol_ready, viol_join, held_cyc;
    bit                timed_out;
    logic [15:0]       bc_after_start;

    bit                c_mode, c_depool;
    int                c_trans, c_ch, c_pix, c_base;
    logic [PE_NUM-1:0] c_mask;

    task automatic set_conf(input bit mode, input int trans, input int chn, input int pixn,
                            input bit depool, input int base, input logic [PE_NUM-1:0] mask);
        @(posedge clk); #1;
        c_mode = mode; c_trans = trans; c_ch = chn; c_pix = pixn; c_depool = depool;
        c_base = base; c_mask = mask;
        conf_mode = mode; conf_trans_num = 16'(trans); conf_ch_num = CH_W'(chn);
        conf_pix_num = PIX_W'(pixn); conf_depool = depool; conf_base_addr = ADDR_W'(base);
        conf_mask = mask;
    endtask

    function automatic int exp_beats();
        int step;
        step = c_depool ? UNIT_N : 1;
        if (!c_mode) return c_trans + 1;
        return (c_ch + 1) * ((c_pix + step) / step);
    endfunction

    // Beat n of a job, from the loading rules: PARAM is linear, UPDATE walks ch inside pix.
    function automatic void model_write(input int n, input logic [DDR_W-1:0] b1, input logic [DDR_W-1:0] b2,
                                        output logic [ADDR_W-1:0] a, output logic [PE_NUM-1:0] en,
                                        output logic [OUT_W-1:0] d);
        int step, ch, pix, lane;
        logic [DDR_W-1:0] w;
        step = c_depool ? UNIT_N : 1;
        if (!c_mode) begin
            a = ADDR_W'((c_base + n) % BUF_DEPTH);
            en = c_mask;
            w = b2;
        end else begin
            ch  = n % (c_ch + 1);
            pix = (n / (c_ch + 1)) * step;
            a = ADDR_W'((c_base + ch * (1 << (PIX_W - LANE_W)) + pix / UNIT_N) % BUF_DEPTH);
            w = b1;
            if (c_depool) begin
                en = c_mask;
                for (int i = 0; i < BATCH; i++)
                    w[i*DATA_W +: DATA_W] = (b2[i*DATA_W +: DATA_W] != 0) ? b1[i*DATA_W +: DATA_W] : '0;
            end else begin
                lane = pix % UNIT_N;
                en = '0;
                for (int p = 0; p < PE_NUM; p++)
                    if (p % UNIT_N == lane) en[p] = c_mask[p];
            end
        end
        d = {UNIT_N{w}};
    endfunction

    // p1 < 0 toggles ddr1_valid every cycle; st_at/st_len force a stall window; mid_start pulses start mid-run.
    task automatic run_job(input int p1, input int p2, input int pstall, input int st_at, input int st_len,
                           input int mid_start, input bit zpat, input int max_cyc);
        logic prev_held;
        logic [ADDR_W-1:0] pa;
        logic [PE_NUM-1:0] pe;
        logic [OUT_W-1:0] pd;
        logic [DDR_W-1:0] w;
        prev_held = 1'b0; pa = '0; pe = '0; pd = '0;
        got_addr.delete(); got_en.delete(); got_data.delete(); got_cyc.delete();
        acc1.delete(); acc2.delete(); acc_cyc.delete();
        viol_hold = 0; viol_ready = 0; viol_join = 0; held_cyc = 0; done_cyc = -1; timed_out = 0;
        bc_after_start = 16'hDEAD;
        for (int c = 0; c < max_cyc; c++) begin
            @(posedge clk); #1;
            start = (c == 0) || (c == mid_start);
            if (c == mid_start) begin
                conf_base_addr = ~conf_base_addr;
                conf_trans_num = 16'd3;
                conf_ch_num = '0;
            end
            ddr1_valid = (p1 < 0) ? c[0] : ($urandom_range(99) < p1);
            ddr2_valid = ($urandom_range(99) < p2);
            ddr1_data = $urandom;
            w = $urandom;
            ddr2_data = zpat ? ((w | 32'h0100_0100) & 32'hFF00_FF00) : w;
            pbuf_stall = (c >= st_at && c < st_at + st_len) || ($urandom_range(99) < pstall);
            @(negedge clk);
            if (c == 1) bc_after_start = beat_cnt;
            if (prev_held && (pbuf_wr_en !== pe || pbuf_wr_addr !== pa || pbuf_wr_data !== pd)) viol_hold++;
            prev_held = pbuf_stall && (pbuf_wr_en != '0);
            if (prev_held) begin
                held_cyc++;
                pa = pbuf_wr_addr; pe = pbuf_wr_en; pd = pbuf_wr_data;
                if (ddr1_ready || ddr2_ready) viol_ready++;
            end
            if (c_mode ? (ddr1_ready !== ddr2_ready || (ddr2_ready && !(ddr1_valid && ddr2_valid)))
                       : (ddr1_ready !== 1'b0)) viol_join++;
            if (pbuf_wr_en != '0 && !pbuf_stall) begin
                got_addr.push_back(pbuf_wr_addr); got_en.push_back(pbuf_wr_en);
                got_data.push_back(pbuf_wr_data); got_cyc.push_back(c);
            end
            if (ddr2_valid && ddr2_ready) begin
                acc1.push_back(ddr1_data); acc2.push_back(ddr2_data); acc_cyc.push_back(c);
            end
            if (c > 0 && done) begin
                done_cyc = c;
                break;
            end
        end
        start = 1'b0; ddr1_valid = 1'b0; ddr2_valid = 1'b0; pbuf_stall = 1'b0;
        if (done_cyc < 0) timed_out = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL reset_done: got %0b want 1", done); end
        checks++; if (ddr1_ready !== 1'b0 || ddr2_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b%0b want 00", ddr1_ready, ddr2_ready); end
        checks++; if (pbuf_wr_en !== '0) begin errors++; $display("FAIL reset_en: got %0h want 0", pbuf_wr_en); end
        checks++; if (pbuf_wr_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0h want 0", pbuf_wr_addr); end
        checks++; if (pbuf_wr_data !== '0) begin errors++; $display("FAIL reset_data: got %0h want 0", pbuf_wr_data); end
        checks++; if (beat_cnt !== 16'd0) begin errors++; $display("FAIL reset_beat_cnt: got %0d want 0", beat_cnt); end
    endtask

    task automatic test_param_basic();
        logic [ADDR_W-1:0] ea; logic [PE_NUM-1:0] ee; logic [OUT_W-1:0] ed;
        set_conf(1'b0, 7, 0, 0, 1'b0, 'hF8, '1);
        run_job(100, 100, 0, -1, 0, -1, 1'b0, 100);
        checks++; if (timed_out) begin errors++; $display("FAIL param_basic_timeout: done never rose"); end
        checks++; if (got_addr.size() != 8 || acc1.size() != 8) begin errors++; $display("FAIL param_basic_count: got %0d writes %0d beats want 8", got_addr.size(), acc1.size()); end
        for (int i = 0; i < got_addr.size() && i < acc1.size() && acc_cyc.size() > 0; i++) begin
            model_write(i, acc1[i], acc2[i], ea, ee, ed);
            checks++;
            if (got_addr[i] !== ea || got_addr[i] !== ADDR_W'(8'hF8 + i) || got_en[i] !== ee || got_data[i] !== ed || got_cyc[i] != acc_cyc[0] + 1 + i)
                begin errors++; $display("FAIL param_basic_write%0d: got %0h/%0h/cyc%0d want %0h/%0h/cyc%0d", i, got_addr[i], got_data[i], got_cyc[i], ea, ed, acc_cyc[0] + 1 + i); end
        end
        if (acc_cyc.size() > 0) begin
            checks++; if (done_cyc != acc_cyc[0] + 9) begin errors++; $display("FAIL param_basic_done_cycle: got %0d want %0d", done_cyc, acc_cyc[0] + 9); end
        end
        checks++; if (beat_cnt !== 16'd8) begin errors++; $display("FAIL param_basic_beat_cnt: got %0d want 8", beat_cnt); end
    endtask

    task automatic test_param_stall();
        logic [ADDR_W-1:0] ea; logic [PE_NUM-1:0] ee; logic [OUT_W-1:0] ed;
        int tn;
        tn = $urandom_range(10, 20);
        set_conf(1'b0, tn, 0, 0, 1'b0, $urandom_range(255), $urandom | 32'h1);
        run_job(100, 100, 0, 5, 3, 8, 1'b0, 200);
        checks++; if (timed_out) begin errors++; $display("FAIL param_stall_timeout: done never rose"); end
        checks++; if (held_cyc != 3) begin errors++; $display("FAIL param_stall_held: got %0d want 3", held_cyc); end
        checks++; if (viol_hold != 0) begin errors++; $display("FAIL param_stall_hold: got %0d changes want 0", viol_hold); end
        checks++; if (viol_ready != 0) begin errors++; $display("FAIL param_stall_ready: got %0d high want 0", viol_ready); end
        checks++; if (got_addr.size() != tn + 1 || acc1.size() != tn + 1) begin errors++; $display("FAIL param_stall_count: got %0d writes %0d beats want %0d", got_addr.size(), acc1.size(), tn + 1); end
        for (int i = 0; i < got_addr.size() && i < acc1.size(); i++) begin
            model_write(i, acc1[i], acc2[i], ea, ee, ed);
            checks++;
            if (got_addr[i] !== ea || got_en[i] !== ee || got_data[i] !== ed)
                begin errors++; $display("FAIL param_stall_write%0d: got %0h/%0h/%0h want %0h/%0h/%0h", i, got_addr[i], got_en[i], got_data[i], ea, ee, ed); end
        end
        checks++; if (beat_cnt !== 16'(tn + 1)) begin errors++; $display("FAIL param_stall_beat_cnt: got %0d want %0d", beat_cnt, tn + 1); end
    endtask

    task automatic test_update();
        logic [ADDR_W-1:0] ea; logic [PE_NUM-1:0] ee; logic [OUT_W-1:0] ed;
        set_conf(1'b1, 0, 1, 7, 1'b0, $urandom_range(255), '1);
        run_job(-1, 70, 0, -1, 0, -1, 1'b0, 300);
        checks++; if (timed_out) begin errors++; $display("FAIL update_timeout: done never rose"); end
        checks++; if (viol_join != 0) begin errors++; $display("FAIL update_joint: got %0d single accepts want 0", viol_join); end
        checks++; if (got_addr.size() != 16 || acc1.size() != 16) begin errors++; $display("FAIL update_count: got %0d writes %0d beats want 16", got_addr.size(), acc1.size()); end
        for (int i = 0; i < got_addr.size() && i < acc1.size(); i++) begin
            model_write(i, acc1[i], acc2[i], ea, ee, ed);
            checks++;
            if (got_addr[i] !== ea || got_en[i] !== ee || got_data[i] !== ed)
                begin errors++; $display("FAIL update_write%0d: got %0h/%0h/%0h want %0h/%0h/%0h", i, got_addr[i], got_en[i], got_data[i], ea, ee, ed); end
        end
        if (got_addr.size() > 11) begin
            checks++; if (got_addr[11] !== ADDR_W'(c_base + 5)) begin errors++; $display("FAIL update_ch1_pix5_addr: got %0h want %0h", got_addr[11], ADDR_W'(c_base + 5)); end
        end
        checks++; if (beat_cnt !== 16'd16) begin errors++; $display("FAIL update_beat_cnt: got %0d want 16", beat_cnt); end
    endtask

    task automatic test_depool();
        logic [ADDR_W-1:0] ea; logic [PE_NUM-1:0] ee; logic [OUT_W-1:0] ed;
        set_conf(1'b1, 0, 1, 7, 1'b1, $urandom_range(255), '1);
        run_job(70, 70, 20, -1, 0, -1, 1'b1, 300);
        checks++; if (timed_out) begin errors++; $display("FAIL depool_timeout: done never rose"); end
        checks++; if (viol_join != 0 || viol_hold != 0 || viol_ready != 0) begin errors++; $display("FAIL depool_protocol: got %0d/%0d/%0d violations want 0", viol_join, viol_hold, viol_ready); end
        checks++; if (got_addr.size() != 4 || acc1.size() != 4) begin errors++; $display("FAIL depool_count: got %0d writes %0d beats want 4", got_addr.size(), acc1.size()); end
        for (int i = 0; i < got_addr.size() && i < acc1.size(); i++) begin
            model_write(i, acc1[i], acc2[i], ea, ee, ed);
            checks++;
            if (got_addr[i] !== ea || got_en[i] !== 32'hFFFF_FFFF || got_data[i] !== ed)
                begin errors++; $display("FAIL depool_write%0d: got %0h/%0h/%0h want %0h/ffffffff/%0h", i, got_addr[i], got_en[i], got_data[i], ea, ed); end
        end
    endtask

    task automatic test_abort();
        int n;
        set_conf(1'b0, 20, 0, 0, 1'b0, 'h40, '1);
        @(posedge clk); #1; start = 1'b1; ddr2_valid = 1'b1; ddr2_data = $urandom;
        @(posedge clk); #1; start = 1'b0;
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(negedge clk);
            if (ddr2_valid && ddr2_ready) n++;
            @(posedge clk); #1;
        end
        checks++; if (n != 3) begin errors++; $display("FAIL abort_setup: got %0d beats want 3", n); end
        ddr2_valid = 1'b0; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        checks++; if (pbuf_wr_en !== '0) begin errors++; $display("FAIL abort_en: got %0h want 0", pbuf_wr_en); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_done: got %0b want 1", done); end
        set_conf(1'b0, 3, 0, 0, 1'b0, 'hA5, '1);
        run_job(100, 100, 0, -1, 0, -1, 1'b0, 100);
        checks++; if (bc_after_start !== 16'd0) begin errors++; $display("FAIL abort_restart_beat_cnt: got %0h want 0", bc_after_start); end
        checks++; if (got_addr.size() != 4) begin errors++; $display("FAIL abort_restart_count: got %0d want 4", got_addr.size()); end
        if (got_addr.size() > 0) begin
            checks++; if (got_addr[0] !== 8'hA5) begin errors++; $display("FAIL abort_restart_addr: got %0h want a5", got_addr[0]); end
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] ea; logic [PE_NUM-1:0] ee; logic [OUT_W-1:0] ed;
        bit md;
        for (int r = 0; r < 6; r++) begin
            md = r[0];
            set_conf(md, $urandom_range(15), $urandom_range(3), $urandom_range(15), $urandom_range(1),
                     $urandom_range(255), md ? ($urandom | 32'hF) : ($urandom | 32'h1));
            run_job($urandom_range(60, 100), $urandom_range(60, 100), $urandom_range(30), -1, 0, -1, 1'b0, 600);
            checks++; if (timed_out || viol_join != 0 || viol_hold != 0 || viol_ready != 0)
                begin errors++; $display("FAIL random%0d_protocol: got timeout=%0b viol=%0d/%0d/%0d want 0", r, timed_out, viol_join, viol_hold, viol_ready); end
            checks++; if (got_addr.size() != exp_beats() || beat_cnt !== 16'(exp_beats()))
                begin errors++; $display("FAIL random%0d_count: got %0d writes beat_cnt %0d want %0d", r, got_addr.size(), beat_cnt, exp_beats()); end
            for (int i = 0; i < got_addr.size() && i < acc1.size(); i++) begin
                model_write(i, acc1[i], acc2[i], ea, ee, ed);
                checks++;
                if (got_addr[i] !== ea || got_en[i] !== ee || got_data[i] !== ed)
                    begin errors++; $display("FAIL random%0d_write%0d: got %0h/%0h/%0h want %0h/%0h/%0h", r, i, got_addr[i], got_en[i], got_data[i], ea, ee, ed); end
            end
        end
    endtask

    task automatic test_reset_mid();
        set_conf(1'b0, 30, 0, 0, 1'b0, 'h10, '1);
        @(posedge clk); #1; start = 1'b1; ddr2_valid = 1'b1; ddr2_data = $urandom;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) begin @(posedge clk); #1; ddr2_data = $urandom; end
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rst_mid_done: got %0b want 1", done); end
        checks++; if (ddr1_ready !== 1'b0 || ddr2_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %0b%0b want 00", ddr1_ready, ddr2_ready); end
        checks++; if (pbuf_wr_en !== '0 || pbuf_wr_addr !== '0 || pbuf_wr_data !== '0)
            begin errors++; $display("FAIL rst_mid_outputs: got %0h/%0h/%0h want 0/0/0", pbuf_wr_en, pbuf_wr_addr, pbuf_wr_data); end
        checks++; if (beat_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_beat_cnt: got %0d want 0", beat_cnt); end
        ddr2_valid = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        test_reset();
        test_param_basic();
        test_param_stall();
        test_update();
        test_depool();
        test_abort();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
